timer_display: RTL and testbench

Drives the 4-digit, 7-segment display from the game timer's BCD outputs (`sec_*` current time, `h_sec_*` high score). It sits directly downstream of `timer`. It multiplexes the four digits using a scan strobe and blanks leading zeros. It shows the high score for a fixed time on a button press, blinks the frozen time after a win, and spells "LOSE" after a loss. It runs on the system clock; `clockdiv`-derived rates arrive as one-cycle enable strobes, not clocks.

---
 rtl/disp_pkg.sv | 40 ++++
 rtl/bcd_to_seg.sv | 27 ++
 rtl/timer_display.sv | 201 ++++++++++++++++++++
 tb/tb_timer_display.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and segment constants for the timer display.
// Segment vectors are seg[6:0] = g..a, active-low (0 lights a segment).
package disp_pkg;

    // Display mode: live time, high score, frozen winning time, loss banner.
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HIGH = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } mode_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Any nibble above 9 decodes to blank; this one is used to force a blank digit.
    localparam logic [3:0] NIB_BLANK = 4'hF;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Active-low one-hot anode pattern for a digit position (3 = leftmost).
    function automatic logic [3:0] anode_of(input logic [1:0] pos);
        return ~(4'b0001 << pos);
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to 7-segment decoder; values above 9 show blank.
module bcd_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one BCD digit.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/timer_display.sv
// 4-digit multiplexed 7-segment driver for the game timer.
// Modes: RUN shows live time, HIGH shows the high score for HOLD_SEC seconds
// after a button press, WIN blinks the time frozen at the win, LOSE spells LOSE.
// seg/an are registered and only change on a scan_en strobe, so a digit's
// segments and its anode always switch in the same cycle.
// dbg_mode exposes the mode register for observation.
module timer_display
    import disp_pkg::*;
#(
    parameter int HOLD_SEC = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       scan_en,
    input  logic       tick_1hz,
    input  logic [3:0] sec_u,
    input  logic [3:0] sec_t,
    input  logic [3:0] sec_h,
    input  logic [3:0] h_sec_u,
    input  logic [3:0] h_sec_t,
    input  logic [3:0] h_sec_h,
    input  logic       win_flag,
    input  logic       lose_flag,
    input  logic       show_btn,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic [1:0] dbg_mode
);

    mode_t      mode_q;
    mode_t      mode_d;
    logic       btn_q;
    logic       btn_rise;
    logic [3:0] hold_cnt;
    logic       blink_vis;
    logic [3:0] frz_u;
    logic [3:0] frz_t;
    logic [3:0] frz_h;
    logic [1:0] idx;
    logic       win_entry;

    logic [3:0] src_u;
    logic [3:0] src_t;
    logic [3:0] src_h;
    logic [3:0] dig_nib;
    logic       use_lit;
    logic [6:0] lit_seg;
    logic [6:0] dec_seg;
    logic [6:0] digit_seg;

    assign btn_rise  = show_btn & ~btn_q;
    assign win_entry = (mode_d == WIN) && (mode_q != WIN);
    assign dp        = 1'b1;
    assign dbg_mode  = mode_q;

    // Previous button level for rising-edge detection.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) btn_q <= 1'b0;
        else     btn_q <= show_btn;
    end

    // Mode state register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) mode_q <= RUN;
        else     mode_q <= mode_d;
    end

    // Next mode: loss overrides everything, win only leaves RUN/HIGH,
    // WIN and LOSE are terminal until reset.
    always_comb begin
        mode_d = mode_q;
        if (lose_flag) begin
            mode_d = LOSE;
        end else begin
            case (mode_q)
                RUN: begin
                    if (win_flag)      mode_d = WIN;
                    else if (btn_rise) mode_d = HIGH;
                end
                HIGH: begin
                    if (win_flag)
                        mode_d = WIN;
                    else if (!btn_rise && tick_1hz && (hold_cnt == 4'd1))
                        mode_d = RUN;
                end
                default: mode_d = mode_q;
            endcase
        end
    end

    // High-score hold countdown; a button edge reloads and beats a same-cycle tick.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hold_cnt <= 4'd0;
        end else if ((mode_d == HIGH) && btn_rise) begin
            hold_cnt <= 4'(HOLD_SEC);
        end else if ((mode_q == HIGH) && tick_1hz && (hold_cnt != 4'd0)) begin
            hold_cnt <= hold_cnt - 4'd1;
        end
    end

    // Capture the live time in the cycle the win is taken.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            frz_u <= 4'd0;
            frz_t <= 4'd0;
            frz_h <= 4'd0;
        end else if (win_entry) begin
            frz_u <= sec_u;
            frz_t <= sec_t;
            frz_h <= sec_h;
        end
    end

    // Blink phase: visible on entering WIN, toggles every second while in WIN.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                             blink_vis <= 1'b1;
        else if (win_entry)                  blink_vis <= 1'b1;
        else if ((mode_q == WIN) && tick_1hz) blink_vis <= ~blink_vis;
    end

    // Choose the number being shown for the current mode.
    always_comb begin
        src_u = sec_u;
        src_t = sec_t;
        src_h = sec_h;
        case (mode_q)
            HIGH: begin
                src_u = h_sec_u;
                src_t = h_sec_t;
                src_h = h_sec_h;
            end
            WIN: begin
                src_u = frz_u;
                src_t = frz_t;
                src_h = frz_h;
            end
            default: begin
                src_u = sec_u;
                src_t = sec_t;
                src_h = sec_h;
            end
        endcase
    end

    // Content of the digit at idx: a letter literal, or a nibble for the
    // decoder with leading zeros forced to blank.
    always_comb begin
        dig_nib = NIB_BLANK;
        use_lit = 1'b0;
        lit_seg = SEG_BLANK;
        if (mode_q == LOSE) begin
            use_lit = 1'b1;
            case (idx)
                2'd3:    lit_seg = SEG_L;
                2'd2:    lit_seg = SEG_O;
                2'd1:    lit_seg = SEG_S;
                default: lit_seg = SEG_E;
            endcase
        end else begin
            case (idx)
                2'd3: begin
                    if (mode_q == HIGH) begin
                        use_lit = 1'b1;
                        lit_seg = SEG_H;
                    end
                end
                2'd2:    dig_nib = (src_h == 4'd0) ? NIB_BLANK : src_h;
                2'd1:    dig_nib = ((src_h == 4'd0) && (src_t == 4'd0)) ? NIB_BLANK : src_t;
                default: dig_nib = src_u;
            endcase
        end
    end

    bcd_to_seg u_dec (
        .bcd (dig_nib),
        .seg (dec_seg)
    );

    assign digit_seg = use_lit ? lit_seg : dec_seg;

    // Scan counter and output registers, advanced together by scan_en.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            idx <= 2'd0;
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (scan_en) begin
            idx <= idx + 2'd1;
            if ((mode_q == WIN) && !blink_vis) begin
                an  <= AN_OFF;
                seg <= SEG_BLANK;
            end else begin
                an  <= anode_of(idx);
                seg <= digit_seg;
            end
        end
    end

endmodule

// File: tb/tb_timer_display.sv
// Self-checking bench for timer_display: directed scenarios followed by
// randomized traffic, all checked against a behavioural display model.
module tb_timer_display;

    localparam int HOLD = 3;
    localparam int M_RUN  = 0;
    localparam int M_HIGH = 1;
    localparam int M_WIN  = 2;
    localparam int M_LOSE = 3;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       scan_en = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [3:0] sec_u = 4'd0, sec_t = 4'd0, sec_h = 4'd0;
    logic [3:0] h_sec_u = 4'd0, h_sec_t = 4'd0, h_sec_h = 4'd0;
    logic       win_flag = 1'b0;
    logic       lose_flag = 1'b0;
    logic       show_btn = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic [1:0] dbg_mode;

    always #5 clk = ~clk;

    timer_display #(.HOLD_SEC(HOLD)) dut (
        .clk      (clk),
        .clr      (clr),
        .scan_en  (scan_en),
        .tick_1hz (tick_1hz),
        .sec_u    (sec_u),
        .sec_t    (sec_t),
        .sec_h    (sec_h),
        .h_sec_u  (h_sec_u),
        .h_sec_t  (h_sec_t),
        .h_sec_h  (h_sec_h),
        .win_flag (win_flag),
        .lose_flag(lose_flag),
        .show_btn (show_btn),
        .seg      (seg),
        .an       (an),
        .dp       (dp),
        .dbg_mode (dbg_mode)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int         m_mode;
    int         m_hold;
    bit         m_vis;
    int         m_idx;
    bit         m_btn;
    logic [3:0] m_fu, m_ft, m_fh;
    logic [6:0] m_seg;
    logic [3:0] m_an;

    function automatic logic [6:0] seg_of(input byte c);
        case (c)
            "0": return 7'b1000000;
            "1": return 7'b1111001;
            "2": return 7'b0100100;
            "3": return 7'b0110000;
            "4": return 7'b0011001;
            "5": return 7'b0010010;
            "6": return 7'b0000010;
            "7": return 7'b1111000;
            "8": return 7'b0000000;
            "9": return 7'b0010000;
            "H": return 7'b0001001;
            "L": return 7'b1000111;
            "O": return 7'b1000000;
            "S": return 7'b0010010;
            "E": return 7'b0000110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic byte nib_char(input logic [3:0] n);
        if (n <= 4'd9) return byte'(8'h30 + {4'd0, n});
        return " ";
    endfunction

    // Character shown at digit position d (3 = leftmost) for the model's mode.
    function automatic byte disp_char(input int d);
        string      banner;
        logic [3:0] u, t, h;
        banner = "LOSE";
        if (m_mode == M_LOSE) return banner[3 - d];
        if (m_mode == M_HIGH)     begin u = h_sec_u; t = h_sec_t; h = h_sec_h; end
        else if (m_mode == M_WIN) begin u = m_fu; t = m_ft; h = m_fh; end
        else                      begin u = sec_u; t = sec_t; h = sec_h; end
        case (d)
            3:       return (m_mode == M_HIGH) ? "H" : " ";
            2:       return (h == 0) ? " " : nib_char(h);
            1:       return (h == 0 && t == 0) ? " " : nib_char(t);
            default: return nib_char(u);
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_RUN; m_hold = 0; m_vis = 1'b1; m_idx = 0; m_btn = 1'b0;
        m_fu = 4'd0; m_ft = 4'd0; m_fh = 4'd0;
        m_seg = 7'b1111111; m_an = 4'b1111;
    endtask

    // One rising clock edge of the model, using the inputs present at the edge.
    task automatic model_edge();
        bit rise;
        int mode_n;
        rise   = show_btn && !m_btn;
        mode_n = m_mode;
        if (scan_en) begin
            if (m_mode == M_WIN && !m_vis) begin
                m_an = 4'b1111; m_seg = 7'b1111111;
            end else begin
                m_an  = ~(4'b0001 << m_idx);
                m_seg = seg_of(disp_char(m_idx));
            end
            m_idx = (m_idx + 1) % 4;
        end
        if (lose_flag) begin
            mode_n = M_LOSE;
        end else if ((m_mode == M_RUN || m_mode == M_HIGH) && win_flag) begin
            mode_n = M_WIN; m_fu = sec_u; m_ft = sec_t; m_fh = sec_h; m_vis = 1'b1;
        end else if (m_mode == M_RUN && rise) begin
            mode_n = M_HIGH; m_hold = HOLD;
        end else if (m_mode == M_HIGH) begin
            if (rise) m_hold = HOLD;
            else if (tick_1hz) begin
                if (m_hold == 1) mode_n = M_RUN;
                m_hold--;
            end
        end else if (m_mode == M_WIN && tick_1hz) begin
            m_vis = !m_vis;
        end
        m_mode = mode_n;
        m_btn  = show_btn;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("seg", 32'(seg), 32'(m_seg));
        check("an", 32'(an), 32'(m_an));
        check("dp", 32'(dp), 32'd1);
        check("mode", 32'(dbg_mode), 32'(m_mode));
    endtask

    task automatic idle_inputs();
        scan_en = 1'b0; tick_1hz = 1'b0; win_flag = 1'b0; lose_flag = 1'b0;
    endtask

    // Assert clr between edges; the display must blank before the next edge.
    task automatic apply_reset();
        @(posedge clk);
        #3 clr = 1'b1;
        #1;
        check("async_seg_blank", 32'(seg), 32'h7f);
        check("async_an_off", 32'(an), 32'hf);
        @(posedge clk);
        #3 clr = 1'b0;
        model_reset();
        #1;
        check("reset_mode", 32'(dbg_mode), 32'(M_RUN));
    endtask

    task automatic scans(input int n);
        for (int i = 0; i < n; i++) begin
            scan_en = 1'b1; step();
            scan_en = 1'b0; step();
        end
    endtask

    task automatic tick();
        tick_1hz = 1'b1; step();
        tick_1hz = 1'b0; step();
    endtask

    task automatic press();
        show_btn = 1'b1; step();
        show_btn = 1'b0; step();
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] exp_an[4];
    logic [6:0] exp_seg[4];

    initial begin
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        #3 clr = 1'b0;
        #1;
        check("reset_an", 32'(an), 32'hf);
        check("reset_seg", 32'(seg), 32'h7f);
        check("reset_dp", 32'(dp), 32'd1);
        apply_reset();

        // Leading-zero blanking on 005.
        sec_h = 4'd0; sec_t = 4'd0; sec_u = 4'd5;
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'b0010010, 7'b1111111, 7'b1111111, 7'b1111111};
        for (int i = 0; i < 4; i++) begin
            scan_en = 1'b1; step(); scan_en = 1'b0;
            check("lz_an", 32'(an), 32'(exp_an[i]));
            check("lz_seg", 32'(seg), 32'(exp_seg[i]));
        end

        // Hundreds present: inner zero must show.
        sec_h = 4'd1; sec_t = 4'd0; sec_u = 4'd7;
        scans(4);

        // High-score hold with re-press extending the hold.
        h_sec_h = 4'd0; h_sec_t = 4'd4; h_sec_u = 4'd2;
        press();
        scans(4);
        tick(); tick();
        check("hold_after2", 32'(dbg_mode), 32'(M_HIGH));
        press();
        tick(); tick();
        check("hold_extended", 32'(dbg_mode), 32'(M_HIGH));
        tick();
        check("hold_expired", 32'(dbg_mode), 32'(M_RUN));
        scans(4);

        // Tick and press in the same cycle while in HIGH: reload wins.
        press();
        tick(); tick();
        show_btn = 1'b1; tick_1hz = 1'b1; step();
        show_btn = 1'b0; tick_1hz = 1'b0; step();
        tick(); tick();
        check("reload_beats_tick", 32'(dbg_mode), 32'(M_HIGH));
        tick();

        // Win freeze and blink.
        sec_h = 4'd0; sec_t = 4'd3; sec_u = 4'd8;
        win_flag = 1'b1; step(); win_flag = 1'b0;
        sec_h = 4'd9; sec_t = 4'd9; sec_u = 4'd1;
        scans(4);
        tick(); scans(4);
        check("blink_off_an", 32'(an), 32'hf);
        tick(); scans(4);
        press(); scans(4);

        // Lose beats win; button ignored; only clr exits.
        apply_reset();
        lose_flag = 1'b1; win_flag = 1'b1; step();
        lose_flag = 1'b0; win_flag = 1'b0;
        press();
        scans(4);
        check("lose_digit3", 32'(seg), 32'b1000111);
        check("lose_sticky", 32'(dbg_mode), 32'(M_LOSE));
        apply_reset();

        // Randomized traffic in rounds, each starting from reset.
        for (int r = 0; r < 16; r++) begin
            apply_reset();
            for (int c = 0; c < 500; c++) begin
                scan_en   = ($urandom_range(0, 2) == 0);
                tick_1hz  = ($urandom_range(0, 11) == 0);
                win_flag  = ($urandom_range(0, 300) == 0);
                lose_flag = ($urandom_range(0, 700) == 0);
                if ($urandom_range(0, 25) == 0) show_btn = ~show_btn;
                if ($urandom_range(0, 30) == 0) begin
                    sec_u = 4'($urandom_range(0, 10));
                    sec_t = 4'($urandom_range(0, 10));
                    sec_h = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 10));
                end
                if ($urandom_range(0, 60) == 0) begin
                    h_sec_u = 4'($urandom_range(0, 10));
                    h_sec_t = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 10));
                    h_sec_h = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 10));
                end
                step();
            end
            idle_inputs();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
